counter_en_ctrl: RTL and testbench

COUNTER_EN_CTRL -- requirements
Module: counter_en_ctrl

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_en_ctrl_if.sv | 21 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/counter_4bit.sv | 31 +++
 rtl/counter_en_ctrl.sv | 99 +++++++++
 tb/tb_counter_en_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the run/pause count-enable controller.
// Also hosts the prescale counter width helper.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_PRESCALE        = 10;

    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_en_ctrl_if.sv
// Control bundle from counter_en_ctrl to the downstream 4-bit counter.
// The controller drives it, the counter consumes it.
interface counter_en_ctrl_if;

    logic en;
    logic cnt_clr;
    logic running;

    modport master (
        output en,
        output cnt_clr,
        output running
    );

    modport slave (
        input en,
        input cnt_clr,
        input running
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer, press detector.
// press is a registered one-cycle pulse on each debounced 0->1 change.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A sample matching the current level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~dly_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            dly_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            dly_q   <= level_q;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/counter_4bit.sv
// Downstream 4-bit counter driven by the controller bundle.
// cnt_clr zeroes it synchronously; en advances it by one.
module counter_4bit (
    input  logic               clk,
    input  logic               rst,
    counter_en_ctrl_if.slave   ctl,
    output logic [3:0]         q
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (ctl.cnt_clr) begin
            q_d = 4'd0;
        end else if (ctl.en) begin
            q_d = q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_en_ctrl.sv
// Run/pause/clear controller producing a prescaled count-enable pulse
// and a one-cycle clear pulse for a downstream counter.
module counter_en_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PRESCALE        = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_clr,
    output logic en,
    output logic cnt_clr,
    output logic running
);

    localparam int unsigned PW = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    logic run_press;
    logic clr_press;

    state_e        state_q, state_d;
    logic [PW-1:0] psc_q, psc_d;
    logic          en_q, en_d;
    logic          clr_q, clr_d;
    logic          running_q, running_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_run),
        .press   (run_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clr),
        .press   (clr_press)
    );

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        if (clr_press) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else if (run_press) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        // Only a cycle that starts and stays in RUN advances the prescaler.
        if (state_q == RUN && state_d == RUN) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                en_d  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
        if (state_d == IDLE) begin
            psc_d = '0;
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            psc_q     <= '0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            en_q      <= en_d;
            clr_q     <= clr_d;
            running_q <= running_d;
        end
    end

    assign en      = en_q;
    assign cnt_clr = clr_q;
    assign running = running_q;

endmodule

// File: tb/tb_counter_en_ctrl.sv
// Directed bench: controller plus 4-bit counter, PRESCALE=10 and PRESCALE=1.
module tb_counter_en_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_clr;
    logic [3:0] q1;
    logic [3:0] q2;
    int         total = 0;
    int         bad = 0;

    counter_en_ctrl_if cif1 ();
    counter_en_ctrl_if cif2 ();

    counter_en_ctrl #(.DEBOUNCE_CYCLES(4), .PRESCALE(10)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .en      (cif1.en),
        .cnt_clr (cif1.cnt_clr),
        .running (cif1.running)
    );

    counter_en_ctrl #(.DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .en      (cif2.en),
        .cnt_clr (cif2.cnt_clr),
        .running (cif2.running)
    );

    counter_4bit cnt1 (.clk(clk), .rst(rst), .ctl(cif1), .q(q1));
    counter_4bit cnt2 (.clk(clk), .rst(rst), .ctl(cif2), .q(q2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        repeat (3) tick();
        total++;
        if ({cif1.en, cif1.cnt_clr, cif1.running} !== 3'b000) begin
            bad++;
            $display("FAIL reset_out1 got=%b exp=000",
                     {cif1.en, cif1.cnt_clr, cif1.running});
        end
        total++;
        if ({cif2.en, cif2.cnt_clr, cif2.running} !== 3'b000) begin
            bad++;
            $display("FAIL reset_out2 got=%b exp=000",
                     {cif2.en, cif2.cnt_clr, cif2.running});
        end
        total++;
        if ({q1, q2} !== 8'h00) begin
            bad++;
            $display("FAIL reset_q got=%h exp=00", {q1, q2});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_start();
        logic exp;
        btn_run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8);
            total++;
            if (cif1.running !== exp) begin
                bad++;
                $display("FAIL start_running k=%0d got=%b exp=%b",
                         k, cif1.running, exp);
            end
            total++;
            if (cif1.en !== 1'b0) begin
                bad++;
                $display("FAIL start_en_early k=%0d got=%b exp=0", k, cif1.en);
            end
        end
        btn_run = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            exp = (j == 10 || j == 20);
            total++;
            if (cif1.en !== exp) begin
                bad++;
                $display("FAIL start_en j=%0d got=%b exp=%b", j, cif1.en, exp);
            end
            total++;
            if (cif2.en !== 1'b1) begin
                bad++;
                $display("FAIL p1_en j=%0d got=%b exp=1", j, cif2.en);
            end
        end
        total++;
        if (q1 !== 4'd1) begin
            bad++;
            $display("FAIL start_q1 got=%0d exp=1", q1);
        end
        total++;
        if (q2 !== 4'd3) begin
            bad++;
            $display("FAIL p1_wrap_q2 got=%0d exp=3", q2);
        end
    endtask

    task automatic test_pause();
        logic exp;
        repeat (10) tick();
        total++;
        if (cif1.en !== 1'b1 || q1 !== 4'd2) begin
            bad++;
            $display("FAIL pause_third_en got=%b/%0d exp=1/2", cif1.en, q1);
        end
        btn_run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k < 8);
            total++;
            if (cif1.running !== exp || cif1.en !== 1'b0) begin
                bad++;
                $display("FAIL pause_enter k=%0d got=%b%b exp=%b0",
                         k, cif1.running, cif1.en, exp);
            end
        end
        btn_run = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (cif1.en !== 1'b0 || cif1.running !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold k=%0d got=%b%b exp=00",
                         k, cif1.running, cif1.en);
            end
        end
        total++;
        if (q1 !== 4'd3) begin
            bad++;
            $display("FAIL pause_q got=%0d exp=3", q1);
        end
        btn_run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8);
            total++;
            if (cif1.running !== exp) begin
                bad++;
                $display("FAIL resume_running k=%0d got=%b exp=%b",
                         k, cif1.running, exp);
            end
        end
        btn_run = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = (k == 3);
            total++;
            if (cif1.en !== exp) begin
                bad++;
                $display("FAIL resume_phase k=%0d got=%b exp=%b", k, cif1.en, exp);
            end
        end
    endtask

    task automatic test_clr_priority();
        logic exp;
        tick();
        total++;
        if (q1 !== 4'd4) begin
            bad++;
            $display("FAIL clr_pre_q got=%0d exp=4", q1);
        end
        btn_run = 1'b1;
        btn_clr = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8);
            total++;
            if (cif1.cnt_clr !== exp || cif1.running !== !exp) begin
                bad++;
                $display("FAIL clr_both k=%0d got=%b%b exp=%b%b",
                         k, cif1.cnt_clr, cif1.running, exp, !exp);
            end
            total++;
            if (cif1.en !== 1'b0) begin
                bad++;
                $display("FAIL clr_en k=%0d got=%b exp=0", k, cif1.en);
            end
        end
        btn_run = 1'b0;
        btn_clr = 1'b0;
        tick();
        total++;
        if ({cif1.cnt_clr, cif1.en, q1, q2} !== 10'd0) begin
            bad++;
            $display("FAIL clr_after got=%b%b/%0d/%0d exp=00/0/0",
                     cif1.cnt_clr, cif1.en, q1, q2);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if ({cif1.en, cif1.running, cif2.en, cif2.running} !== 4'b0000) begin
                bad++;
                $display("FAIL clr_idle k=%0d got=%b exp=0000", k,
                         {cif1.en, cif1.running, cif2.en, cif2.running});
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 6; i++) begin
            btn_run = (i % 2 == 0);
            tick();
        end
        btn_run = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            total++;
            if (cif1.running !== 1'b0 || cif1.en !== 1'b0) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b%b exp=00",
                         k, cif1.running, cif1.en);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        btn_run = 1'b1;
        repeat (8) tick();
        btn_run = 1'b0;
        repeat (5) tick();
        total++;
        if (cif1.running !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got=%b exp=1", cif1.running);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({cif1.en, cif1.cnt_clr, cif1.running, cif2.running} !== 4'b0000) begin
            bad++;
            $display("FAIL rmid_out got=%b exp=0000",
                     {cif1.en, cif1.cnt_clr, cif1.running, cif2.running});
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (cif1.en !== 1'b0 || cif1.running !== 1'b0) begin
                bad++;
                $display("FAIL rmid_idle k=%0d got=%b%b exp=00",
                         k, cif1.running, cif1.en);
            end
        end
        btn_run = 1'b1;
        repeat (8) tick();
        btn_run = 1'b0;
        total++;
        if (cif1.running !== 1'b1) begin
            bad++;
            $display("FAIL rmid_restart got=%b exp=1", cif1.running);
        end
        for (int j = 1; j <= 10; j++) begin
            tick();
            exp = (j == 10);
            total++;
            if (cif1.en !== exp) begin
                bad++;
                $display("FAIL rmid_en j=%0d got=%b exp=%b", j, cif1.en, exp);
            end
        end
    endtask

    task automatic test_held_reset();
        logic exp;
        rst = 1'b0;
        btn_run = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8);
            total++;
            if (cif1.running !== exp) begin
                bad++;
                $display("FAIL held_rst k=%0d got=%b exp=%b",
                         k, cif1.running, exp);
            end
        end
        btn_run = 1'b0;
        btn_clr = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8);
            total++;
            if (cif1.cnt_clr !== exp || cif1.running !== !exp) begin
                bad++;
                $display("FAIL clr_only k=%0d got=%b%b exp=%b%b",
                         k, cif1.cnt_clr, cif1.running, exp, !exp);
            end
        end
        btn_clr = 1'b0;
        tick();
        total++;
        if (cif1.cnt_clr !== 1'b0) begin
            bad++;
            $display("FAIL clr_one_cycle got=%b exp=0", cif1.cnt_clr);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_clr_priority();
        test_bounce();
        test_reset_mid();
        test_held_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
